// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer reader: FSM state encoding,
// default timer width and the layout of one captured FIFO entry.
package timer_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // One captured sample at the default width: value, delta to the
  // previous capture, and the first-since-start marker.
  typedef struct packed {
    logic [TIMER_W-1:0] data;
    logic [TIMER_W-1:0] delta;
    logic               first;
  } timer_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy counter.
// The head word is presented combinationally from storage (no write-through
// bypass). The caller is responsible for only pushing when there is room
// or when a pop happens on the same edge; flush has priority over push/pop.
module sync_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/timer_reader.sv
// Consumer end of the timer interface: arms the timer, captures qualified
// timer words with the modular delta to the previous capture, and buffers
// them for a valid/ready downstream. A capture on a start edge is dropped,
// because start flushes the buffer on that same edge.
module timer_reader
  import timer_pkg::*;
#(
  parameter int W     = TIMER_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         t_valid,
  input  logic [W-1:0] t_out,
  output logic         t_en,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [W-1:0] s_data,
  output logic [W-1:0] s_delta,
  output logic         s_first,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] delta;
    logic         first;
  } entry_t;

  state_e       state_q, state_d;
  logic         ovf_q, ovf_d;
  logic         first_q, first_d;
  logic [W-1:0] prev_q, prev_d;
  logic         t_en_q, busy_q;

  logic          capture_s, push_s, pop_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s, count_next_s;
  entry_t        push_entry_s, head_s;

  assign pop_s     = !fifo_empty_s && s_ready;
  assign capture_s = t_valid && (state_q != ST_IDLE) && !start;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_s    = capture_s && (!fifo_full_s || pop_s);

  assign push_entry_s.data  = t_out;
  assign push_entry_s.delta = t_out - prev_q;
  assign push_entry_s.first = first_q;

  assign count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);

  sync_fifo #(
    .WIDTH (2 * W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign s_valid = !fifo_empty_s;
  assign s_data  = head_s.data;
  assign s_delta = head_s.delta;
  assign s_first = head_s.first;
  assign t_en    = t_en_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;

  // Next-state logic: start always (re)enters RUN; RUN/STALL track FIFO room after this edge.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   if (stop) state_d = ST_IDLE;
                  else if (count_next_s == CW'(DEPTH)) state_d = ST_STALL;
                  else state_d = ST_RUN;
        ST_STALL: if (stop) state_d = ST_IDLE;
                  else if (count_next_s < CW'(DEPTH)) state_d = ST_RUN;
                  else state_d = ST_STALL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Capture bookkeeping: accepted samples advance prev/first, rejected ones raise ovf.
  always_comb begin
    ovf_d   = ovf_q;
    first_d = first_q;
    prev_d  = prev_q;
    if (start) begin
      ovf_d   = 1'b0;
      first_d = 1'b1;
    end else if (push_s) begin
      prev_d  = t_out;
      first_d = 1'b0;
    end else if (capture_s) begin
      ovf_d   = 1'b1;
    end else begin
      ovf_d   = ovf_q;
    end
  end

  // State and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      prev_q  <= {W{1'b0}};
      t_en_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
      prev_q  <= prev_d;
      t_en_q  <= (state_d == ST_RUN);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_timer_reader.sv
// Self-checking bench for timer_reader: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_timer_reader;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, t_valid, s_ready;
  logic [W-1:0] t_out;
  logic         t_en, s_valid, s_first, ovf, busy;
  logic [W-1:0] s_data, s_delta;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] dl;
    logic         f;
  } ent_t;

  // Behavioural model: buffered entries, capturing-or-not, sticky drop, last value.
  ent_t         mq[$];
  bit           m_active;
  bit           m_ovf;
  bit           m_first;
  logic [W-1:0] m_prev;

  timer_reader #(.W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .t_valid (t_valid),
    .t_out   (t_out),
    .t_en    (t_en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_delta (s_delta),
    .s_first (s_first),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_first  = 1'b1;
    m_prev   = '0;
  endtask

  task automatic check_outputs();
    chk("s_valid", {31'd0, s_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("s_data",  {16'd0, s_data},  {16'd0, mq[0].d});
      chk("s_delta", {16'd0, s_delta}, {16'd0, mq[0].dl});
      chk("s_first", {31'd0, s_first}, {31'd0, mq[0].f});
    end
    chk("t_en", {31'd0, t_en}, {31'd0, m_active && (mq.size() < DEPTH)});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
  endtask

  // One clock: drive inputs, advance the model by the rules, then check after the edge.
  task automatic step(input bit st, input bit sp, input bit tv, input logic [W-1:0] to, input bit rdy);
    bit   pop;
    ent_t e;
    start = st; stop = sp; t_valid = tv; t_out = to; s_ready = rdy;
    pop = (mq.size() > 0) && rdy;
    if (st) begin
      mq.delete();
      m_active = 1'b1;
      m_ovf    = 1'b0;
      m_first  = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_active && tv) begin
        if (mq.size() < DEPTH) begin
          e.d = to; e.dl = to - m_prev; e.f = m_first;
          mq.push_back(e);
          m_prev  = to;
          m_first = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (sp) m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; t_valid = 1'b0; t_out = '0; s_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_data",  {16'd0, s_data},  32'd0);
    chk("rst_s_delta", {16'd0, s_delta}, 32'd0);
    chk("rst_s_first", {31'd0, s_first}, 32'd0);
    chk("rst_t_en",    {31'd0, t_en},    32'd0);
    chk("rst_ovf",     {31'd0, ovf},     32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    #4 rst = 1'b1;

    // Basic capture with an always-ready consumer.
    step(0, 0, 1, 16'd99, 1);   // ignored while idle
    step(1, 0, 0, 16'd0, 1);
    chk("basic_t_en", {31'd0, t_en}, 32'd1);
    step(0, 0, 1, 16'd10, 1);
    chk("basic1", {15'd0, s_data, s_first}, {15'd0, 16'd10, 1'b1});
    chk("basic1_delta", {16'd0, s_delta}, 32'd10);
    step(0, 0, 1, 16'd20, 1);
    chk("basic2", {s_data, s_delta}, {16'd20, 16'd10});
    step(0, 0, 1, 16'd35, 1);
    chk("basic3", {s_data, s_delta}, {16'd35, 16'd15});
    step(0, 0, 0, 16'd0, 1);

    // Backpressure to full, overflow, then one pop resumes.
    step(1, 0, 0, 16'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(100 + i), 0);
    chk("full_t_en", {31'd0, t_en}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    step(0, 0, 1, 16'd200, 0);
    chk("full_ovf", {31'd0, ovf}, 32'd1);
    chk("full_head", {16'd0, s_data}, 32'd100);
    step(0, 0, 0, 16'd0, 1);
    chk("resume_t_en", {31'd0, t_en}, 32'd1);

    // Full with simultaneous push and pop.
    step(1, 0, 0, 16'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(300 + i), 0);
    step(0, 0, 1, 16'd400, 1);
    chk("pp_ovf", {31'd0, ovf}, 32'd0);
    chk("pp_t_en", {31'd0, t_en}, 32'd0);
    chk("pp_head", {16'd0, s_data}, 32'd301);

    // Timer wrap-around delta.
    step(1, 0, 0, 16'd0, 0);
    step(0, 0, 1, 16'hFFFE, 0);
    step(0, 0, 1, 16'h0002, 0);
    step(0, 0, 0, 16'd0, 1);
    chk("wrap_delta", {16'd0, s_delta}, 32'h0004);
    step(0, 0, 0, 16'd0, 1);

    // Stop keeps queued entries; restart flushes.
    step(1, 0, 0, 16'd0, 0);
    step(0, 0, 1, 16'd5, 0);
    step(0, 0, 1, 16'd9, 0);
    step(0, 1, 0, 16'd0, 0);
    chk("stop_t_en", {31'd0, t_en}, 32'd0);
    step(0, 0, 1, 16'd77, 0);
    chk("stop_ignored", {31'd0, s_valid}, 32'd1);
    step(0, 0, 0, 16'd0, 1);
    step(0, 0, 0, 16'd0, 1);
    chk("stop_drained", {31'd0, s_valid}, 32'd0);
    step(0, 0, 1, 16'd1, 0);
    step(0, 0, 1, 16'd2, 0);
    step(1, 0, 0, 16'd0, 0);
    chk("restart_flush", {31'd0, s_valid}, 32'd0);
    step(0, 0, 1, 16'd50, 0);
    chk("restart_first", {31'd0, s_first}, 32'd1);
    step(0, 1, 0, 16'd0, 1);
    step(1, 1, 0, 16'd0, 1);
    chk("start_wins", {31'd0, busy}, 32'd1);

    // Asynchronous reset between edges with entries queued.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'(60 + i), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("arst_t_en",    {31'd0, t_en},    32'd0);
    chk("arst_ovf",     {31'd0, ovf},     32'd0);
    chk("arst_busy",    {31'd0, busy},    32'd0);
    #1 rst = 1'b1;
    model_reset();
    step(0, 0, 1, 16'd8, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit st, sp, tv, rdy;
      st  = ($urandom_range(0, 39) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      tv  = st ? 1'b0 : ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      step(st, sp, tv, 16'($urandom), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timer_reader.md
Name: timer_reader

Overview:
Consumer end of the timer interface. It arms the timer through t_en and captures each t_out word qualified by t_valid. It also computes the modular delta to the previous capture. Captures are buffered in a small FIFO and delivered downstream over a valid/ready handshake. Sits between the timer and any logging or display logic.

Parameters:
W, 16, width of t_out / captured value
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: clear state and begin capturing
stop  input  1  single-cycle pulse: stop capturing
t_valid  input  1  timer output qualifier
t_out  input  W  timer value
t_en  output  1  timer enable
s_valid  output  1  FIFO head valid
s_ready  input  1  downstream accepts head
s_data  output  W  captured t_out at FIFO head
s_delta  output  W  (s_data - previous capture) mod 2^W
s_first  output  1  head is first capture since start
ovf  output  1  sticky: a sample was dropped
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low. While rst=0:
  - state=IDLE, FIFO empty, t_en=0, s_valid=0, ovf=0.
  - s_data, s_delta and s_first are all zero.
  - prev register=0, first flag=1.
- Registered outputs: t_en, ovf and busy are registered. s_* are driven directly from the FIFO head.
- FSM states: IDLE, RUN, STALL.
  - IDLE: t_en=0. start -> RUN, and on the same edge flush the FIFO, clear ovf and set first=1.
  - RUN: t_en=1. stop -> IDLE. Else if the FIFO becomes full after this edge's push/pop -> STALL.
  - STALL: t_en=0. stop -> IDLE. Else if count < DEPTH after this edge -> RUN.
  - start in RUN or STALL restarts: flush, clear ovf, first=1, go to RUN.
  - start and stop in the same cycle: start wins.
- Capture:
  - Any cycle with t_valid=1 while state != IDLE is a capture attempt, including STALL, because one sample may already be in flight.
  - t_valid in IDLE is ignored.
- Push rule:
  - A capture is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - The pushed entry is {t_out, t_out - prev, first}. Then prev <= t_out and first <= 0.
  - A rejected capture sets ovf=1. prev and first are unchanged.
- Pop rule:
  - Pop occurs when s_valid && s_ready.
  - s_valid=1 iff count > 0. The head is stable while s_valid=1 and s_ready=0.
- Latency and pointers:
  - A capture at edge N is visible at s_valid/s_data after edge N (one-cycle latency).
  - The FIFO does not bypass combinationally when empty.
  - Pointers wrap modulo DEPTH. count runs 0..DEPTH.
- Delta arithmetic: subtraction is unsigned and mod 2^W. Timer wrap therefore gives the correct elapsed count, e.g. 0x0002 - 0xFFFE = 0x0004.
- Stop behaviour: stop does not flush. Remaining entries drain normally in IDLE.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are lost.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, STALL}
  - the default W=16
  - a struct/typedef for the FIFO entry {data[W], delta[W], first}
- One natural sub-module: sync_fifo (parameterised width and DEPTH, push/pop/full/empty/count, flush input).
- The FSM and delta logic live in timer_reader.

Test Plan:
1. Basic capture:
   - Stimulus: rst low 5 ns then high; start; timer produces t_valid with t_out=10, 20, 35; s_ready=1.
   - Response: t_en=1 from the cycle after start. Outputs (data, delta, first) = (10, 10, 1), (20, 10, 0), (35, 15, 0), each one cycle after its t_valid.
2. Backpressure to full:
   - Stimulus: s_ready=0; 4 captures.
   - Response: state=STALL, t_en=0. A 5th t_valid sets ovf=1 and the FIFO keeps the first 4.
   - Then s_ready=1 for one cycle: one pop, state=RUN, t_en=1.
3. Full with simultaneous push/pop:
   - Stimulus: FIFO full, s_ready=1 and t_valid=1 in the same cycle.
   - Response: push accepted, count stays 4, ovf stays 0.
4. Wrap-around:
   - Stimulus: captures 0xFFFE then 0x0002.
   - Response: second entry delta=0x0004.
5. Stop/restart:
   - Stimulus: stop with 2 entries queued.
   - Response: t_en=0 next cycle, t_valid ignored, 2 entries still drain.
   - Stimulus: start.
   - Response: FIFO flushed, ovf cleared, next capture has first=1. start+stop together -> RUN.
6. Async reset mid-run:
   - Stimulus: rst low between clock edges with 3 entries queued.
   - Response: s_valid, t_en, ovf and busy go 0 immediately, before the next edge. After release the block is in IDLE with the FIFO empty.
